mw_keypad_scanner: RTL and testbench
====================================

// Module: mw_keypad_scanner
// PURPOSE
//  4x4 matrix keypad scanner/encoder for the microwave front panel; drives rows, reads columns.
//  Debounces presses and releases; emits one-clock command pulses: keypad[9:0] one-hot, startn, stopn, clear_keyn.
//  Output bundle connects directly to the keypad/startn/stopn inputs of the microwave controller.
//  Key map [row][col]: r0: 1 2 3 START | r1: 4 5 6 STOP | r2: 7 8 9 CLEAR | r3: * 0 # (unused).
// PARAMETERS
//  SCAN_DIV          16  clock cycles per row slot; columns sampled in last cycle of slot (>=2)
//  DEBOUNCE_SAMPLES  4   consecutive agreeing samples needed to accept a press or a release (>=1)
// PORTS
//  clk         in   1   system clock, rising edge
//  clearn      in   1   asynchronous active-low reset
//  col_n       in   4   column lines, active-low (external pull-ups), asynchronous to clk
//  row_n       out  4   row drive, active-low, exactly one bit low at all times
//  keypad      out  10  one-hot digit pulse, bit d = digit d, 1 clk wide
//  startn      out  1   active-low 1-clk pulse on START
//  stopn       out  1   active-low 1-clk pulse on STOP
//  clear_keyn  out  1   active-low 1-clk pulse on CLEAR (command only; not a reset)
//  key_code    out  4   code of last accepted key = {row,col}; held until next accept
//  key_held    out  1   high while an accepted key is still down (HELD/RELEASE states)
// BEHAVIOUR
//  Reset (async, clearn=0): state=SCAN, row_idx=0, row_n=4'b1110, div=0, deb_cnt=0,
//   keypad=0, startn=stopn=clear_keyn=1, key_code=0, key_held=0, synchronizer flops=4'b1111.
//  col_n passes through 2-flop synchronizer; all decisions use synced value (2-clk input latency).
//  div counts 0..SCAN_DIV-1 in every state; "sample" = cycle where div==SCAN_DIV-1; div wraps to 0.
//  row_n = ~(4'b0001 << row_idx); row_idx changes only at a sample boundary in SCAN.
//  Valid sample = exactly one synced column low; zero or >=2 low = "no key" (multi-key rejected).
//  FSM:
//   SCAN: at sample: valid -> DEBOUNCE, cand={row_idx,col}, deb_cnt=1 (row held);
//         else row_idx=(row_idx+1) mod 4 (3 wraps to 0).
//   DEBOUNCE: at sample: valid && same cand -> deb_cnt+1; on reaching DEBOUNCE_SAMPLES -> HELD, accept;
//         otherwise (different/no key) -> SCAN, row_idx advances, deb_cnt=0. DEBOUNCE_SAMPLES=1: accept at SCAN sample.
//   HELD: key_held=1; at sample: no key -> RELEASE, deb_cnt=1; any key -> stay (no repeat, no new pulse).
//   RELEASE: at sample: no key -> deb_cnt+1, reaching DEBOUNCE_SAMPLES -> SCAN, row_idx advances, key_held=0;
//         any key low -> HELD, deb_cnt=0 (bounce on release produces no second pulse).
//  Accept: registered on the accepting sample edge; pulse output valid the following cycle for exactly 1 clk.
//   Digit -> keypad[d]=1; START->startn=0; STOP->stopn=0; CLEAR->clear_keyn=0; * # unused -> key_code
//   updates, key_held=1, no pulse. Never more than one pulse output active in any cycle.
//  Press-to-pulse latency from stable col_n: <= 4*SCAN_DIV (scan reach) + DEBOUNCE_SAMPLES*SCAN_DIV + 3 clks.
//  Row held during DEBOUNCE/HELD/RELEASE: other keys invisible until release accepted.
//  Reset mid-operation: any state, pulse aborted immediately (outputs to reset values asynchronously).
// TESTING (SCAN_DIV=4, DEBOUNCE_SAMPLES=3, clk 50 ns)
//  Reset: clearn=0 -> row_n=1110, keypad=0, startn=stopn=clear_keyn=1, key_held=0; idle: row_n cycles 1110,1101,1011,0111 every 4 clks.
//  Press '2' (r0,c1: col_n=1101 when row_n=1110) held 40 clks -> exactly one clk keypad=10'b0000000100, key_code=4'b0001.
//  Press START held, then bounce col_n 3 toggles on release -> one startn low pulse, key_held falls once, no second pulse.
//  Glitch '5' lasting 2 samples (< 3) -> no keypad pulse, FSM returns to SCAN, row advances to r2.
//  '1' and '3' pressed together (col_n=1010 on r0) -> no pulse; release '3' keeping '1' -> keypad[1] pulse.
//  Press '0' (r3,c1) -> keypad[0] pulse; assert clearn=0 during DEBOUNCE of '8' -> no pulse, row_n=1110 immediately.

Source files
------------

// File: rtl/mw_keypad_scanner_if.sv
// mw_keypad_scanner_if: keypad matrix lines and decoded command bundle
interface mw_keypad_scanner_if;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [9:0] keypad;
   logic       startn;
   logic       stopn;
   logic       clear_keyn;
   logic [3:0] key_code;
   logic       key_held;
   modport master (
      input  col_n,
      output row_n, keypad, startn, stopn, clear_keyn, key_code, key_held
   );
   modport slave (
      output col_n,
      input  row_n, keypad, startn, stopn, clear_keyn, key_code, key_held
   );
endinterface

// File: rtl/mw_keypad_scanner.sv
// mw_keypad_scanner: 4x4 keypad row scanner with press/release debounce and one-clock command pulses
module mw_keypad_scanner #(
   parameter int SCAN_DIV         = 16,
   parameter int DEBOUNCE_SAMPLES = 4
) (
   input logic                 clk,
   input logic                 clearn,
   mw_keypad_scanner_if.master kp_if
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
   state_t        state_q;
   logic [3:0]    sync1_q, sync2_q, cand_q, key_code_q, code;
   logic [DW-1:0] div_q;
   logic [CW-1:0] deb_q;
   logic [1:0]    row_q, col;
   logic [9:0]    keypad_q, keypad_d;
   logic          startn_q, stopn_q, clear_keyn_q, key_held_q;
   logic          startn_d, stopn_d, clear_keyn_d;
   logic          sample, valid, deb_done, accept, release_done;
   // column decode of the synced sample and command decode of the key under the active row
   always_comb begin
      valid        = sync2_q inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
      col          = !sync2_q[0] ? 2'd0 : !sync2_q[1] ? 2'd1 : !sync2_q[2] ? 2'd2 : 2'd3;
      code         = {row_q, col};
      sample       = div_q == DW'(SCAN_DIV - 1);
      deb_done     = deb_q + CW'(1) == CW'(DEBOUNCE_SAMPLES);
      keypad_d     = (row_q != 2'd3 && col != 2'd3) ? 10'd1 << ({2'b0, row_q} * 4'd3 + {2'b0, col} + 4'd1)
                   : (code == 4'b1101) ? 10'd1 : 10'd0;
      startn_d     = code != 4'b0011;
      stopn_d      = code != 4'b0111;
      clear_keyn_d = code != 4'b1011;
      accept       = sample && valid && ((state_q == SCAN && DEBOUNCE_SAMPLES == 1) ||
                     (state_q == DEBOUNCE && code == cand_q && deb_done));
      release_done = sample && !valid && ((state_q == HELD && DEBOUNCE_SAMPLES == 1) ||
                     (state_q == RELEASE && deb_done));
   end
   // synchronizer, slot divider, scan/debounce FSM and registered command outputs
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         state_q      <= SCAN;
         sync1_q      <= 4'hf;
         sync2_q      <= 4'hf;
         cand_q       <= '0;
         key_code_q   <= '0;
         div_q        <= '0;
         deb_q        <= '0;
         row_q        <= '0;
         keypad_q     <= '0;
         startn_q     <= 1'b1;
         stopn_q      <= 1'b1;
         clear_keyn_q <= 1'b1;
         key_held_q   <= 1'b0;
      end else begin
         sync1_q      <= kp_if.col_n;
         sync2_q      <= sync1_q;
         div_q        <= sample ? '0 : div_q + DW'(1);
         keypad_q     <= accept ? keypad_d : '0;
         startn_q     <= !accept || startn_d;
         stopn_q      <= !accept || stopn_d;
         clear_keyn_q <= !accept || clear_keyn_d;
         if (accept) begin
            key_code_q <= code;
            key_held_q <= 1'b1;
            state_q    <= HELD;
            deb_q      <= '0;
         end else if (release_done) begin
            key_held_q <= 1'b0;
            state_q    <= SCAN;
            row_q      <= row_q + 2'd1;
            deb_q      <= '0;
         end else if (sample) begin
            case (state_q)
               SCAN: begin
                  state_q <= valid ? DEBOUNCE : SCAN;
                  cand_q  <= code;
                  deb_q   <= valid ? CW'(1) : '0;
                  row_q   <= valid ? row_q : row_q + 2'd1;
               end
               DEBOUNCE: begin
                  state_q <= (valid && code == cand_q) ? DEBOUNCE : SCAN;
                  deb_q   <= (valid && code == cand_q) ? deb_q + CW'(1) : '0;
                  row_q   <= (valid && code == cand_q) ? row_q : row_q + 2'd1;
               end
               HELD: begin
                  state_q <= valid ? HELD : RELEASE;
                  deb_q   <= valid ? '0 : CW'(1);
               end
               default: begin
                  state_q <= valid ? HELD : RELEASE;
                  deb_q   <= valid ? '0 : deb_q + CW'(1);
               end
            endcase
         end
      end
   end
   assign kp_if.row_n      = ~(4'b0001 << row_q);
   assign kp_if.keypad     = keypad_q;
   assign kp_if.startn     = startn_q;
   assign kp_if.stopn      = stopn_q;
   assign kp_if.clear_keyn = clear_keyn_q;
   assign kp_if.key_code   = key_code_q;
   assign kp_if.key_held   = key_held_q;
endmodule

// File: tb/tb_mw_keypad_scanner.sv
// tb_mw_keypad_scanner: keypad-matrix model driving the scanner with directed key presses
module tb_mw_keypad_scanner;
   logic        clk = 1'b0;
   logic        clearn = 1'b0;
   logic [15:0] keys = '0;
   logic [3:0]  col_model;
   int nvec = 0, nerr = 0;
   int kp_cnt = 0, st_cnt = 0, sp_cnt = 0, cl_cnt = 0, multi_cnt = 0, fall_cnt = 0;
   logic [9:0] kp_last = '0;
   logic       held_prev = 1'b0;

   mw_keypad_scanner_if kp_if ();
   mw_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SAMPLES(3)) dut (.clk(clk), .clearn(clearn), .kp_if(kp_if));

   always #25 clk = ~clk;

   // physical matrix: a pressed key pulls its column low while its row is driven
   always_comb begin
      col_model = 4'hf;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !kp_if.row_n[r]) col_model[c] = 1'b0;
   end
   assign kp_if.col_n = col_model;

   // pulse bookkeeping sampled away from the active edge
   always @(negedge clk) begin
      if (kp_if.keypad != 0) begin
         kp_cnt  <= kp_cnt + 1;
         kp_last <= kp_if.keypad;
      end
      if (!kp_if.startn) st_cnt <= st_cnt + 1;
      if (!kp_if.stopn) sp_cnt <= sp_cnt + 1;
      if (!kp_if.clear_keyn) cl_cnt <= cl_cnt + 1;
      if ($countones(kp_if.keypad) + 32'(!kp_if.startn) + 32'(!kp_if.stopn) + 32'(!kp_if.clear_keyn) > 1)
         multi_cnt <= multi_cnt + 1;
      if (held_prev && !kp_if.key_held) fall_cnt <= fall_cnt + 1;
      held_prev <= kp_if.key_held;
   end

   typedef struct {
      logic [15:0] keys;
      logic [9:0]  kp;
      logic [2:0]  cmd;
      logic [3:0]  code;
      logic        held;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_row_entry(input logic [3:0] target);
      int t = 0;
      while (kp_if.row_n == target && t < 40) begin @(negedge clk); t++; end
      while (kp_if.row_n != target && t < 40) begin @(negedge clk); t++; end
      if (t >= 40) begin
         nerr++;
         $display("FAIL wait_row: row_n=%b never reached %b", kp_if.row_n, target);
      end
   endtask

   initial begin
      int s_kp, s_st, s_sp, s_cl, s_fall;
      tbl[0]  = '{16'h0002, 10'h004, 3'b000, 4'h1, 1'b1};
      tbl[1]  = '{16'h0020, 10'h020, 3'b000, 4'h5, 1'b1};
      tbl[2]  = '{16'h0400, 10'h200, 3'b000, 4'hA, 1'b1};
      tbl[3]  = '{16'h2000, 10'h001, 3'b000, 4'hD, 1'b1};
      tbl[4]  = '{16'h0008, 10'h000, 3'b100, 4'h3, 1'b1};
      tbl[5]  = '{16'h0080, 10'h000, 3'b010, 4'h7, 1'b1};
      tbl[6]  = '{16'h0800, 10'h000, 3'b001, 4'hB, 1'b1};
      tbl[7]  = '{16'h1000, 10'h000, 3'b000, 4'hC, 1'b1};
      tbl[8]  = '{16'h4000, 10'h000, 3'b000, 4'hE, 1'b1};
      tbl[9]  = '{16'h0005, 10'h000, 3'b000, 4'hE, 1'b0};
      tbl[10] = '{16'h0200, 10'h100, 3'b000, 4'h9, 1'b1};
      tbl[11] = '{16'h0001, 10'h002, 3'b000, 4'h0, 1'b1};

      cycles(3);
      chk("rst_row_n", 32'(kp_if.row_n), 32'hE);
      chk("rst_keypad", 32'(kp_if.keypad), 0);
      chk("rst_cmds", {29'd0, kp_if.startn, kp_if.stopn, kp_if.clear_keyn}, 32'h7);
      chk("rst_held", 32'(kp_if.key_held), 0);
      chk("rst_code", 32'(kp_if.key_code), 0);
      clearn = 1'b1;
      wait_row_entry(4'b1101);
      cycles(4); chk("idle_row2", 32'(kp_if.row_n), 32'hB);
      cycles(4); chk("idle_row3", 32'(kp_if.row_n), 32'h7);
      cycles(4); chk("idle_row0", 32'(kp_if.row_n), 32'hE);

      foreach (tbl[i]) begin
         s_kp = kp_cnt; s_st = st_cnt; s_sp = sp_cnt; s_cl = cl_cnt;
         keys = tbl[i].keys;
         cycles(48);
         chk($sformatf("v%0d_held_down", i), 32'(kp_if.key_held), 32'(tbl[i].held));
         keys = '0;
         cycles(32);
         chk($sformatf("v%0d_kp_pulses", i), kp_cnt - s_kp, 32'(tbl[i].kp != 0));
         if (tbl[i].kp != 0) chk($sformatf("v%0d_kp_val", i), 32'(kp_last), 32'(tbl[i].kp));
         chk($sformatf("v%0d_start", i), st_cnt - s_st, 32'(tbl[i].cmd[2]));
         chk($sformatf("v%0d_stop", i), sp_cnt - s_sp, 32'(tbl[i].cmd[1]));
         chk($sformatf("v%0d_clear", i), cl_cnt - s_cl, 32'(tbl[i].cmd[0]));
         chk($sformatf("v%0d_code", i), 32'(kp_if.key_code), 32'(tbl[i].code));
         chk($sformatf("v%0d_held_up", i), 32'(kp_if.key_held), 0);
      end

      // START with a bouncing release
      s_st = st_cnt; s_kp = kp_cnt; s_fall = fall_cnt;
      keys = 16'h0008; cycles(48);
      chk("bounce_held", 32'(kp_if.key_held), 1);
      keys = '0; cycles(5);
      keys = 16'h0008; cycles(5);
      keys = '0; cycles(5);
      keys = 16'h0008; cycles(5);
      keys = '0; cycles(32);
      chk("bounce_start_pulses", st_cnt - s_st, 1);
      chk("bounce_held_falls", fall_cnt - s_fall, 1);
      chk("bounce_kp_pulses", kp_cnt - s_kp, 0);

      // '5' seen on only two samples: rejected, scan moves on to r2
      s_kp = kp_cnt;
      wait_row_entry(4'b1101);
      keys = 16'h0020; cycles(8);
      keys = '0; cycles(4);
      chk("glitch_row_r2", 32'(kp_if.row_n), 32'hB);
      cycles(4);
      chk("glitch_row_r3", 32'(kp_if.row_n), 32'h7);
      chk("glitch_held", 32'(kp_if.key_held), 0);
      cycles(16);
      chk("glitch_kp_pulses", kp_cnt - s_kp, 0);

      // '1'+'3' rejected, then '3' lifted leaves '1' accepted
      s_kp = kp_cnt;
      keys = 16'h0005; cycles(48);
      chk("combo_no_pulse", kp_cnt - s_kp, 0);
      chk("combo_not_held", 32'(kp_if.key_held), 0);
      keys = 16'h0001; cycles(48);
      chk("combo_one_held", 32'(kp_if.key_held), 1);
      keys = '0; cycles(32);
      chk("combo_one_pulse", kp_cnt - s_kp, 1);
      chk("combo_one_val", 32'(kp_last), 32'h002);

      // reset asserted while '8' is debouncing
      s_kp = kp_cnt;
      wait_row_entry(4'b1011);
      keys = 16'h0200; cycles(6);
      #10 clearn = 1'b0;
      #1;
      chk("midrst_row_n", 32'(kp_if.row_n), 32'hE);
      chk("midrst_held", 32'(kp_if.key_held), 0);
      chk("midrst_code", 32'(kp_if.key_code), 0);
      keys = '0;
      cycles(3);
      clearn = 1'b1;
      cycles(40);
      chk("midrst_no_pulse", kp_cnt - s_kp, 0);

      chk("never_two_pulses", multi_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
